// File: rtl/ex_load_bypass_unit.sv
// EX-slot operand holder that resolves load-use hazards by bypassing MEM load data into flagged operands.
// Optional stall-cycle counter is enabled by defining LOAD_STALL_COUNTER_EN.
module ex_load_bypass_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [1:0]       id_fwd,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic             mem_load_valid,
  input  logic [XLEN-1:0]  mem_load_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_op_a,
  output logic [XLEN-1:0]  ex_op_b,
  output logic             stall_out,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {EMPTY, WAIT_LOAD, READY} state_t;

  state_t          state_q, state_d;
  logic [1:0]      flag_q, flag_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic            fire;
  logic            accept;

  // A flushed instruction is never offered to EX, so flush also masks ex_valid.
  always_comb begin
    ex_valid = 1'b0;
    ex_op_a  = op_a_q;
    ex_op_b  = op_b_q;
    case (state_q)
      WAIT_LOAD: begin
        ex_valid = mem_load_valid & ~flush;
        if (flag_q[0]) ex_op_a = mem_load_data;
        if (flag_q[1]) ex_op_b = mem_load_data;
      end
      READY:   ex_valid = ~flush;
      default: ;
    endcase
  end

  assign fire      = ex_valid & ex_ready;
  assign id_ready  = (state_q == EMPTY) | fire;
  assign stall_out = ~id_ready;
  assign accept    = id_valid & id_ready & ~flush;

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    if (flush) begin
      state_d = EMPTY;
      flag_d  = 2'b00;
    end else if (accept) begin
      op_a_d  = id_rdata1;
      op_b_d  = id_rdata2;
      flag_d  = id_fwd;
      state_d = (id_fwd != 2'b00) ? WAIT_LOAD : READY;
    end else if (fire) begin
      state_d = EMPTY;
      flag_d  = 2'b00;
    end else if (state_q == WAIT_LOAD && mem_load_valid) begin
      // EX is back-pressuring: keep the one-cycle load pulse in the operand regs.
      if (flag_q[0]) op_a_d = mem_load_data;
      if (flag_q[1]) op_b_d = mem_load_data;
      flag_d  = 2'b00;
      state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      flag_q  <= 2'b00;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

`ifdef LOAD_STALL_COUNTER_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating; only reset clears it so it accumulates across flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_LOAD && !mem_load_valid && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ex_load_bypass_unit.sv
// Directed self-checking bench for ex_load_bypass_unit; inputs change 1 time unit after posedge,
// outputs are sampled on the negedge of the same cycle.
module tb_ex_load_bypass_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
`ifdef LOAD_STALL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, id_valid, id_ready;
  logic [1:0]       id_fwd;
  logic [XLEN-1:0]  id_rdata1, id_rdata2, mem_load_data, ex_op_a, ex_op_b;
  logic             mem_load_valid, ex_valid, ex_ready, stall_out;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] exp_cnt;
  int               tests = 0;
  int               fails = 0;

  always #5 clk = ~clk;

  ex_load_bypass_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_fwd(id_fwd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .mem_load_valid(mem_load_valid), .mem_load_data(mem_load_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .stall_out(stall_out), .stall_cycles(stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_fwd = 2'b00; id_rdata1 = '0; id_rdata2 = '0;
    mem_load_valid = 1'b0; mem_load_data = '0; ex_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
    tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL reset_stall_out got=%0b exp=0", stall_out); end
    tests++; if (ex_op_a !== 32'h0) begin fails++; $display("FAIL reset_op_a got=%h exp=0", ex_op_a); end
    tests++; if (ex_op_b !== 32'h0) begin fails++; $display("FAIL reset_op_b got=%h exp=0", ex_op_b); end
    tests++; if (stall_cycles !== 16'h0) begin fails++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    $display("[TB] reset done");
  endtask

  task automatic test_no_fwd();
    step();
    id_valid = 1'b1; id_fwd = 2'b00; id_rdata1 = 32'h11; id_rdata2 = 32'h22; ex_ready = 1'b1;
    sample();
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL nofwd_accept_ready got=%0b exp=1", id_ready); end
    step();
    id_rdata1 = 32'h33; id_rdata2 = 32'h44;
    sample();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL nofwd_valid1 got=%0b exp=1", ex_valid); end
    tests++; if (ex_op_a !== 32'h11) begin fails++; $display("FAIL nofwd_op_a1 got=%h exp=11", ex_op_a); end
    tests++; if (ex_op_b !== 32'h22) begin fails++; $display("FAIL nofwd_op_b1 got=%h exp=22", ex_op_b); end
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL nofwd_b2b_ready got=%0b exp=1", id_ready); end
    step();
    id_valid = 1'b0;
    sample();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL nofwd_valid2 got=%0b exp=1", ex_valid); end
    tests++; if (ex_op_a !== 32'h33) begin fails++; $display("FAIL nofwd_op_a2 got=%h exp=33", ex_op_a); end
    tests++; if (ex_op_b !== 32'h44) begin fails++; $display("FAIL nofwd_op_b2 got=%h exp=44", ex_op_b); end
    step();
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL nofwd_drain got=%0b exp=0", ex_valid); end
    $display("[TB] no_fwd: two back-to-back instructions issued");
  endtask

  task automatic test_load_rs1();
    step();
    id_valid = 1'b1; id_fwd = 2'b01; id_rdata1 = 32'hDEAD; id_rdata2 = 32'h5;
    step();
    id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL rs1_stall_c%0d got=%0b exp=1", i, stall_out); end
      tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rs1_wait_valid_c%0d got=%0b exp=0", i, ex_valid); end
      step();
    end
    mem_load_valid = 1'b1; mem_load_data = 32'hCAFE0001;
    sample();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL rs1_valid got=%0b exp=1", ex_valid); end
    tests++; if (ex_op_a !== 32'hCAFE0001) begin fails++; $display("FAIL rs1_op_a got=%h exp=cafe0001", ex_op_a); end
    tests++; if (ex_op_b !== 32'h5) begin fails++; $display("FAIL rs1_op_b got=%h exp=5", ex_op_b); end
    tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL rs1_fire_stall got=%0b exp=0", stall_out); end
    step();
    mem_load_valid = 1'b0; mem_load_data = '0;
    exp_cnt = CNT_EN ? 16'd3 : 16'd0;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rs1_after got=%0b exp=0", ex_valid); end
    tests++; if (stall_cycles !== exp_cnt) begin fails++; $display("FAIL rs1_stall_cycles got=%0d exp=%0d", stall_cycles, exp_cnt); end
    $display("[TB] load_rs1: op_a=%h op_b=5 after 3 stall cycles", 32'hCAFE0001);
  endtask

  task automatic test_both_flags();
    step();
    id_valid = 1'b1; id_fwd = 2'b11; id_rdata1 = 32'h1; id_rdata2 = 32'h2;
    step();
    id_valid = 1'b0; mem_load_valid = 1'b1; mem_load_data = 32'h7;
    sample();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL both_valid got=%0b exp=1", ex_valid); end
    tests++; if (ex_op_a !== 32'h7) begin fails++; $display("FAIL both_op_a got=%h exp=7", ex_op_a); end
    tests++; if (ex_op_b !== 32'h7) begin fails++; $display("FAIL both_op_b got=%h exp=7", ex_op_b); end
    step();
    mem_load_valid = 1'b0;
    sample();
    tests++; if (stall_cycles !== exp_cnt) begin fails++; $display("FAIL both_stall_cycles got=%0d exp=%0d", stall_cycles, exp_cnt); end
    $display("[TB] both_flags: op_a=op_b=7");
  endtask

  task automatic test_backpressure();
    step();
    id_valid = 1'b1; id_fwd = 2'b10; id_rdata1 = 32'h99; id_rdata2 = 32'h1;
    step();
    id_valid = 1'b0; ex_ready = 1'b0; mem_load_valid = 1'b1; mem_load_data = 32'hABCD;
    sample();
    tests++; if (ex_op_b !== 32'hABCD) begin fails++; $display("FAIL bp_bypass_op_b got=%h exp=abcd", ex_op_b); end
    tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL bp_stall got=%0b exp=1", stall_out); end
    step();
    mem_load_valid = 1'b0; mem_load_data = 32'hFFFF;
    for (int i = 0; i < 2; i++) begin
      sample();
      tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid_c%0d got=%0b exp=1", i, ex_valid); end
      tests++; if (ex_op_b !== 32'hABCD) begin fails++; $display("FAIL bp_hold_op_b_c%0d got=%h exp=abcd", i, ex_op_b); end
      tests++; if (ex_op_a !== 32'h99) begin fails++; $display("FAIL bp_hold_op_a_c%0d got=%h exp=99", i, ex_op_a); end
      step();
    end
    ex_ready = 1'b1;
    sample();
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL bp_fire_ready got=%0b exp=1", id_ready); end
    tests++; if (ex_op_b !== 32'hABCD) begin fails++; $display("FAIL bp_fire_op_b got=%h exp=abcd", ex_op_b); end
    step();
    mem_load_data = '0;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL bp_single_fire got=%0b exp=0", ex_valid); end
    tests++; if (stall_cycles !== exp_cnt) begin fails++; $display("FAIL bp_stall_cycles got=%0d exp=%0d", stall_cycles, exp_cnt); end
    $display("[TB] backpressure: op_b=abcd held then fired once");
  endtask

  task automatic test_flush();
    step();
    id_valid = 1'b1; id_fwd = 2'b01; id_rdata1 = 32'h55; id_rdata2 = 32'h66;
    step();
    flush = 1'b1; id_fwd = 2'b00;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_cycle_valid got=%0b exp=0", ex_valid); end
    step();
    flush = 1'b0; id_valid = 1'b0; mem_load_valid = 1'b1; mem_load_data = 32'h77;
    exp_cnt = CNT_EN ? 16'd4 : 16'd0;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_late_load_valid got=%0b exp=0", ex_valid); end
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL flush_id_ready got=%0b exp=1", id_ready); end
    step();
    mem_load_valid = 1'b0;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_after_valid got=%0b exp=0", ex_valid); end
    tests++; if (stall_cycles !== exp_cnt) begin fails++; $display("FAIL flush_stall_cycles got=%0d exp=%0d", stall_cycles, exp_cnt); end
    $display("[TB] flush: slot emptied, id instruction dropped");
  endtask

  task automatic test_rst_in_wait();
    step();
    id_valid = 1'b1; id_fwd = 2'b01; id_rdata1 = 32'h12; id_rdata2 = 32'h34;
    step();
    id_valid = 1'b0; rst = 1'b1; mem_load_valid = 1'b1; mem_load_data = 32'hFF;
    step();
    rst = 1'b0; mem_load_valid = 1'b0;
    sample();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rstw_valid got=%0b exp=0", ex_valid); end
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL rstw_id_ready got=%0b exp=1", id_ready); end
    tests++; if (ex_op_a !== 32'h0) begin fails++; $display("FAIL rstw_op_a got=%h exp=0", ex_op_a); end
    tests++; if (ex_op_b !== 32'h0) begin fails++; $display("FAIL rstw_op_b got=%h exp=0", ex_op_b); end
    tests++; if (stall_cycles !== 16'h0) begin fails++; $display("FAIL rstw_stall_cycles got=%0d exp=0", stall_cycles); end
    $display("[TB] rst_in_wait: state cleared");
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_no_fwd();
    test_load_rs1();
    test_both_flags();
    test_backpressure();
    test_flush();
    test_rst_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_load_bypass_unit.md
Name: ex_load_bypass_unit

Overview:
- Consumer end of the register file's 2-bit load-use forwarding flags (bit0 = Rs1, bit1 = Rs2), sitting between the ID/EX boundary and the ALU.
- Holds one EX-slot instruction's operands.
- For each flagged operand, substitutes the load data returned by the MEM stage.
- Stalls ID until that data arrives, then presents resolved operands to EX through a valid/ready handshake.

Parameters:
- XLEN, 32, operand and load data width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the EX-slot instruction (branch/exception)
- id_valid  in  1  ID stage offers an instruction
- id_ready  out  1  slot can accept this cycle
- id_fwd  in  2  load-use flags from register file; bit0 Rs1, bit1 Rs2
- id_rdata1  in  XLEN  Rs1 value read/bypassed in ID
- id_rdata2  in  XLEN  Rs2 value read/bypassed in ID
- mem_load_valid  in  1  MEM stage load data valid (single-cycle pulse)
- mem_load_data  in  XLEN  load data from MEM stage
- ex_valid  out  1  operands resolved and offered to EX
- ex_ready  in  1  EX accepts operands
- ex_op_a  out  XLEN  resolved operand A
- ex_op_b  out  XLEN  resolved operand B
- stall_out  out  1  freeze PC and IF/ID; equals ~id_ready
- stall_cycles  out  CNT_W  cycles spent waiting for load data

Behaviour:
- Reset: state EMPTY, flag regs 0, operand regs 0, stall_cycles 0. Outputs after reset: ex_valid 0, id_ready 1, stall_out 0, ex_op_a/b 0.
- States:
  - EMPTY: no instruction in slot.
  - WAIT_LOAD: at least one flag set, data not yet seen.
  - READY: operands resolved.
- fire = ex_valid & ex_ready.
- id_ready = (state == EMPTY) | fire. stall_out = ~id_ready.
- accept = id_valid & id_ready & ~flush.
  - On accept: latch id_rdata1/2 and id_fwd.
  - Next state is WAIT_LOAD if id_fwd != 0, else READY.
- WAIT_LOAD:
  - ex_valid = mem_load_valid.
  - ex_op_a = mem_load_data if flag0, else the latched rdata1. ex_op_b likewise with flag1 and rdata2. This is a combinational bypass, zero added latency.
  - On mem_load_valid & ~ex_ready: write mem_load_data into each flagged operand reg, clear flags, go to READY. The single-cycle data pulse must not be lost.
  - On mem_load_valid & ex_ready: fire. Next state is per accept, else EMPTY.
  - With no mem_load_valid: hold indefinitely.
- READY:
  - ex_valid = 1; operands come from regs.
  - On fire: accept the next instruction in the same cycle (back-to-back), or go to EMPTY.
- EMPTY: mem_load_valid is ignored.
- Both flags set: both operands take the same mem_load_data.
- flush:
  - Any state goes to EMPTY next cycle; flags cleared.
  - Same-cycle id_valid is not accepted.
  - A mem_load_valid in the flush cycle is not captured.
- Priority: rst > flush > fire/accept > load capture.
- Latency: unflagged instruction reaches ex_valid 1 cycle after accept. Flagged instruction reaches ex_valid in the same cycle as mem_load_valid, at the earliest 1 cycle after accept.

Optional Feature:
- Macro: LOAD_STALL_COUNTER_EN.
- Defined:
  - stall_cycles increments by 1 on each cycle with state == WAIT_LOAD and no mem_load_valid.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst; flush does not clear it.
- Not defined: stall_cycles is tied to 0 and no counter flops are inferred.

Test Plan:
- No forwarding: id_fwd=00, rdata1=0x11, rdata2=0x22, ex_ready=1 → next cycle ex_valid=1, op_a=0x11, op_b=0x22; back-to-back accepts with id_ready held 1.
- Load-use on Rs1: id_fwd=01, rdata1=0xDEAD, rdata2=0x5; mem_load_valid 3 cycles later with data 0xCAFE0001 → stall_out=1 for those 3 cycles; then ex_valid=1, op_a=0xCAFE0001, op_b=0x5; stall_cycles=3 with macro, 0 without.
- Both flags: id_fwd=11, load data 0x7 arrives 1 cycle after accept → op_a=op_b=0x7 same cycle, no stall cycle counted.
- Downstream backpressure: id_fwd=10, ex_ready=0 when load data 0xABCD pulses → state READY; ex_ready raised 2 cycles later → op_b=0xABCD still presented, fires once.
- Flush in WAIT_LOAD: id_fwd=01, flush pulsed, mem_load_valid next cycle → ex_valid stays 0, state EMPTY, id_ready=1.
- rst asserted during WAIT_LOAD with a simultaneous mem_load_valid → next cycle ex_valid=0, id_ready=1, ex_op_a/b=0, stall_cycles=0.
